// File: rtl/midi_tx_encode_if.sv
// midi_tx_encode_if: note event handshake into the MIDI transmitter.
// master drives the event, slave (the encoder) answers with evReady.
interface midi_tx_encode_if;
    logic       evValid;
    logic       evReady;
    logic       evNoteOn;
    logic [3:0] evChannel;
    logic [6:0] evNote;
    logic [6:0] evVelocity;

    modport master (
        output evValid, evNoteOn, evChannel, evNote, evVelocity,
        input  evReady
    );

    modport slave (
        input  evValid, evNoteOn, evChannel, evNote, evVelocity,
        output evReady
    );
endinterface

// File: rtl/midi_tx_encode.sv
// midi_tx_encode: note-on/off events to 3-byte MIDI messages on an
// 8N1 UART line, with optional running-status elision and a byte tap.
module midi_tx_encode #(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 31250,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic                   clk,
    input  logic                   nReset,
    midi_tx_encode_if.slave        ev,
    output logic                   txd,
    output logic [7:0]             byteOut,
    output logic                   byteStrobe,
    output logic                   busy
);
    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STATUS,
        NOTE,
        VEL
    } stateT;

    stateT         state;
    logic [CW-1:0] bitCnt;
    logic [3:0]    bitIdx;
    logic [7:0]    noteByte;
    logic [7:0]    velByte;
    logic [7:0]    lastStatus;
    logic          lastStatusValid;
    logic          evReadyQ;
    logic [7:0]    statusByte;
    logic          elide;

    assign ev.evReady = evReadyQ;
    assign busy       = ~evReadyQ;

    // Status byte of the offered event and whether running status drops it
    always_comb begin
        statusByte = {1'b1, 2'b00, ev.evNoteOn, ev.evChannel};
        elide      = RUNNING_STATUS && lastStatusValid
                     && (statusByte == lastStatus);
    end

    // Byte sequencer and bit serialiser; every output is registered
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state           <= IDLE;
            evReadyQ        <= 1'b1;
            txd             <= 1'b1;
            byteStrobe      <= 1'b0;
            byteOut         <= 8'h00;
            bitCnt          <= '0;
            bitIdx          <= 4'd0;
            noteByte        <= 8'h00;
            velByte         <= 8'h00;
            lastStatus      <= 8'h00;
            lastStatusValid <= 1'b0;
        end else begin
            byteStrobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ev.evValid) begin
                        noteByte   <= {1'b0, ev.evNote};
                        velByte    <= {1'b0, ev.evVelocity};
                        evReadyQ   <= 1'b0;
                        txd        <= 1'b0;
                        byteStrobe <= 1'b1;
                        bitCnt     <= '0;
                        bitIdx     <= 4'd0;
                        if (elide) begin
                            state   <= NOTE;
                            byteOut <= {1'b0, ev.evNote};
                        end else begin
                            state           <= STATUS;
                            byteOut         <= statusByte;
                            lastStatus      <= statusByte;
                            lastStatusValid <= 1'b1;
                        end
                    end
                end
                STATUS, NOTE, VEL: begin
                    if (bitCnt != LAST_CNT) begin
                        bitCnt <= bitCnt + 1'b1;
                    end else begin
                        bitCnt <= '0;
                        if (bitIdx != 4'd9) begin
                            // Index 0 is the start bit, 1..8 data, 9 stop
                            bitIdx <= bitIdx + 4'd1;
                            if (bitIdx == 4'd8) begin
                                txd <= 1'b1;
                            end else begin
                                txd <= byteOut[bitIdx[2:0]];
                            end
                        end else begin
                            bitIdx <= 4'd0;
                            if (state == STATUS) begin
                                state      <= NOTE;
                                byteOut    <= noteByte;
                                txd        <= 1'b0;
                                byteStrobe <= 1'b1;
                            end else if (state == NOTE) begin
                                state      <= VEL;
                                byteOut    <= velByte;
                                txd        <= 1'b0;
                                byteStrobe <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                evReadyQ <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_tx_encode.sv
// tb_midi_tx_encode: random note events against a message-level model;
// txd is decoded mid-bit and cross-checked with the byte tap.
module tb_midi_tx_encode;
    localparam int BC = 8;
    localparam int FRAME = 10 * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] nRst;
    logic [1:0] vld;
    logic [1:0] on;
    logic [3:0] ch [2];
    logic [6:0] nt [2];
    logic [6:0] vl [2];
    logic [1:0] txd;
    logic [1:0] strobe;
    logic [1:0] busy;
    logic [1:0] rdy;
    logic [7:0] bOut [2];

    int nTests = 0;
    int nFail = 0;

    logic [7:0] expQ [2][$];
    logic [7:0] strobeQ [2][$];
    logic [7:0] rxQ [2][$];
    logic [7:0] mLast [2];
    bit         mLastValid [2];

    midi_tx_encode_if evIf0 ();
    midi_tx_encode_if evIf1 ();

    assign evIf0.evValid    = vld[0];
    assign evIf0.evNoteOn   = on[0];
    assign evIf0.evChannel  = ch[0];
    assign evIf0.evNote     = nt[0];
    assign evIf0.evVelocity = vl[0];
    assign rdy[0]           = evIf0.evReady;
    assign evIf1.evValid    = vld[1];
    assign evIf1.evNoteOn   = on[1];
    assign evIf1.evChannel  = ch[1];
    assign evIf1.evNote     = nt[1];
    assign evIf1.evVelocity = vl[1];
    assign rdy[1]           = evIf1.evReady;

    midi_tx_encode #(
        .CLK_HZ(8), .BAUD(1), .RUNNING_STATUS(1'b0)
    ) dut0 (
        .clk(clk), .nReset(nRst[0]), .ev(evIf0),
        .txd(txd[0]), .byteOut(bOut[0]),
        .byteStrobe(strobe[0]), .busy(busy[0])
    );

    midi_tx_encode #(
        .CLK_HZ(8), .BAUD(1), .RUNNING_STATUS(1'b1)
    ) dut1 (
        .clk(clk), .nReset(nRst[1]), .ev(evIf1),
        .txd(txd[1]), .byteOut(bOut[1]),
        .byteStrobe(strobe[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Message-level model: appends expected wire bytes, returns count
    function automatic int modelEvent(int d, bit isOn, logic [3:0] c,
                                      logic [6:0] n, logic [6:0] v);
        logic [7:0] s;
        int nb;
        s = (isOn ? 8'h90 : 8'h80) + {4'h0, c};
        nb = 2;
        if (!(d == 1 && mLastValid[d] && mLast[d] == s)) begin
            expQ[d].push_back(s);
            mLast[d] = s;
            mLastValid[d] = 1'b1;
            nb = 3;
        end
        expQ[d].push_back({1'b0, n});
        expQ[d].push_back({1'b0, v});
        return nb;
    endfunction

    // Decode each frame from txd mid-bit, starting at its strobe
    task automatic monitor(int d);
        logic [9:0] fr;
        logic [7:0] snap;
        bit ab;
        forever begin
            @(negedge clk);
            if (nRst[d] && strobe[d]) begin
                snap = bOut[d];
                ab = 1'b0;
                fr = '0;
                strobeQ[d].push_back(snap);
                for (int t = 1; t <= 76; t++) begin
                    @(negedge clk);
                    if (!nRst[d]) ab = 1'b1;
                    if (!ab) check("strobe_mid_frame", 32'(strobe[d]), 0);
                    if (t % 8 == 4) fr[t/8] = txd[d];
                end
                if (!ab) begin
                    check("start_bit", 32'(fr[0]), 0);
                    check("stop_bit", 32'(fr[9]), 1);
                    check("txd_vs_byteOut", 32'(fr[8:1]), 32'(snap));
                    check("byteOut_hold", 32'(bOut[d]), 32'(snap));
                    rxQ[d].push_back(fr[8:1]);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic compareQueues(int d, string tag);
        check({tag, "_strobe_count"}, 32'(strobeQ[d].size()),
              32'(expQ[d].size()));
        check({tag, "_rx_count"}, 32'(rxQ[d].size()),
              32'(expQ[d].size()));
        for (int i = 0; i < expQ[d].size(); i++) begin
            if (i < strobeQ[d].size())
                check({tag, "_tap_byte"}, 32'(strobeQ[d][i]),
                      32'(expQ[d][i]));
            if (i < rxQ[d].size())
                check({tag, "_line_byte"}, 32'(rxQ[d][i]),
                      32'(expQ[d][i]));
        end
        expQ[d].delete();
        strobeQ[d].delete();
        rxQ[d].delete();
    endtask

    task automatic sendEvent(int d, bit isOn, logic [3:0] c,
                             logic [6:0] n, logic [6:0] v);
        int k;
        int nb;
        k = 0;
        while (!rdy[d] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(rdy[d]), 1);
        on[d] = isOn;
        ch[d] = c;
        nt[d] = n;
        vl[d] = v;
        vld[d] = 1'b1;
        nb = modelEvent(d, isOn, c, n, v);
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        on[d] = 1'($urandom_range(0, 1));
        ch[d] = 4'($urandom_range(0, 15));
        nt[d] = 7'($urandom_range(0, 127));
        vl[d] = 7'($urandom_range(0, 127));
        check("start_txd", 32'(txd[d]), 0);
        check("start_strobe", 32'(strobe[d]), 1);
        check("busy_after_accept", 32'(busy[d]), 1);
        k = 0;
        while (k < 1000) begin
            @(posedge clk);
            k++;
            #1;
            if (rdy[d]) break;
        end
        check("ready_latency", 32'(k), 32'(nb * FRAME));
        check("idle_txd", 32'(txd[d]), 1);
        check("idle_busy", 32'(busy[d]), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rn;
        logic [6:0] rv;
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] pNote;
        logic [6:0] pVel;
        bit playing;
        int cnt;
        int acc;
        int guard;

        nRst = 2'b00;
        vld = 2'b11;
        on = 2'b11;
        for (int i = 0; i < 2; i++) begin
            ch[i] = 4'h0;
            nt[i] = 7'd1;
            vl[i] = 7'd1;
            mLast[i] = 8'h00;
            mLastValid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_txd", 32'(txd[d]), 1);
            check("rst_ready", 32'(rdy[d]), 1);
            check("rst_busy", 32'(busy[d]), 0);
            check("rst_strobe", 32'(strobe[d]), 0);
            check("rst_byteOut", 32'(bOut[d]), 0);
        end
        @(negedge clk);
        vld = 2'b00;
        nRst = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle_ready", 32'(rdy[1]), 1);
        check("post_rst_idle_txd", 32'(txd[1]), 1);

        sendEvent(1, 1'b1, 4'd0, 7'd60, 7'd100);
        sendEvent(1, 1'b1, 4'd0, 7'd64, 7'd80);
        sendEvent(1, 1'b0, 4'd3, 7'd60, 7'd0);
        sendEvent(1, 1'b0, 4'd3, 7'd61, 7'd5);
        compareQueues(1, "directed");

        for (int i = 0; i < 6; i++) begin
            sendEvent(1, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 2)),
                      7'($urandom_range(0, 127)),
                      7'($urandom_range(0, 127)));
        end
        compareQueues(1, "random");

        vld[1] = 1'b1;
        acc = 0;
        guard = 0;
        while (acc < 3 && guard < 3000) begin
            @(negedge clk);
            guard++;
            on[1] = 1'($urandom_range(0, 1));
            ch[1] = 4'($urandom_range(0, 1));
            nt[1] = 7'($urandom_range(0, 127));
            vl[1] = 7'($urandom_range(0, 127));
            if (rdy[1]) begin
                void'(modelEvent(1, on[1], ch[1], nt[1], vl[1]));
                acc++;
            end
        end
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        check("held_valid_accepts", 32'(acc), 3);
        guard = 0;
        while (!rdy[1] && guard < 1000) begin
            @(posedge clk);
            guard++;
            #1;
        end
        check("held_valid_drain", 32'(rdy[1]), 1);
        compareQueues(1, "held_valid");

        on[1] = 1'b1;
        ch[1] = 4'd0;
        nt[1] = 7'd60;
        vl[1] = 7'd100;
        vld[1] = 1'b1;
        void'(modelEvent(1, 1'b1, 4'd0, 7'd60, 7'd100));
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        repeat (FRAME + 42) @(posedge clk);
        #2;
        nRst[1] = 1'b0;
        @(posedge clk);
        #1;
        nRst[1] = 1'b1;
        check("midrst_txd", 32'(txd[1]), 1);
        check("midrst_ready", 32'(rdy[1]), 1);
        check("midrst_strobe", 32'(strobe[1]), 0);
        mLastValid[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("midrst_strobes", 32'(strobeQ[1].size()), 2);
        check("midrst_rx_bytes", 32'(rxQ[1].size()), 1);
        expQ[1].delete();
        strobeQ[1].delete();
        rxQ[1].delete();
        sendEvent(1, 1'b1, 4'd0, 7'd62, 7'd90);
        compareQueues(1, "after_reset");

        rn = 7'($urandom_range(0, 127));
        rv = 7'($urandom_range(1, 127));
        sendEvent(0, 1'b1, 4'd5, rn, rv);
        sendEvent(0, 1'b1, 4'd5, rn, rv);
        playing = 1'b0;
        st = 8'h00;
        d1 = 7'd0;
        pNote = 7'd0;
        pVel = 7'd0;
        cnt = 0;
        foreach (strobeQ[0][i]) begin
            if (strobeQ[0][i][7]) begin
                st = strobeQ[0][i];
                cnt = 0;
            end else if (cnt == 0) begin
                d1 = strobeQ[0][i][6:0];
                cnt = 1;
            end else begin
                cnt = 0;
                if (st[7:4] == 4'h9 && strobeQ[0][i] != 8'h00) begin
                    playing = 1'b1;
                    pNote = d1;
                    pVel = strobeQ[0][i][6:0];
                end else if (d1 == pNote) begin
                    playing = 1'b0;
                end
            end
        end
        check("loop_playing", 32'(playing), 1);
        check("loop_note", 32'(pNote), 32'(rn));
        check("loop_vel", 32'(pVel), 32'(rv));
        compareQueues(0, "no_running_status");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
